// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stall_ctrl
// Description : Pipeline-control responder for a 5-stage MIPS pipeline.
//               Turns hazard-unit stall/branch requests and the data-memory
//               wait into PC / IF-ID / ID-EX / downstream-hold controls,
//               sequences multi-cycle branch flushes, flags stuck memory
//               waits and keeps saturating stall/flush counters.
// Ports       : clk, rst                   - clock, sync active-high reset
//               load_use_req, branch_req   - hazard unit requests
//               mem_wait                   - data memory not ready
//               pc_we, ifid_we, ifid_flush - fetch-side controls
//               idex_bubble, pipe_hold     - decode/back-end controls
//               mem_timeout                - sticky stuck-wait flag
//               stall_cnt, flush_cnt       - performance counters
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl #(
    parameter int BRANCH_SLOTS = 1,
    parameter int MAX_WAIT     = 15,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use_req,
    input  logic             branch_req,
    input  logic             mem_wait,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_hold,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_FLUSH = 1'b1;

    localparam logic [3:0] c_slots_m1 = 4'(BRANCH_SLOTS - 1);
    localparam logic [7:0] c_max_wait = 8'(MAX_WAIT);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [3:0]       r_flush_left;
    logic [3:0]       w_flush_left_nxt;
    logic [7:0]       r_wait_cnt;
    logic             r_mem_timeout;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_wait_hit;

    // Control outputs and next-state decode, priority rst > mem_wait > FLUSH
    // squash > load-use > branch.
    always_comb begin
        pc_we            = 1'b1;
        ifid_we          = 1'b1;
        ifid_flush       = 1'b0;
        idex_bubble      = 1'b0;
        pipe_hold        = 1'b0;
        w_state_nxt      = r_state;
        w_flush_left_nxt = r_flush_left;
        if (rst) begin
            pc_we            = 1'b0;
            ifid_we          = 1'b0;
            ifid_flush       = 1'b1;
            idex_bubble      = 1'b1;
            w_state_nxt      = S_RUN;
            w_flush_left_nxt = 4'd0;
        end else if (mem_wait) begin
            // Whole pipe frozen; FSM state is held so a flush resumes later.
            pc_we     = 1'b0;
            ifid_we   = 1'b0;
            pipe_hold = 1'b1;
        end else if (r_state == S_FLUSH) begin
            // ID holds a wrong-path instruction, so requests from it are ignored.
            ifid_flush       = 1'b1;
            w_flush_left_nxt = r_flush_left - 4'd1;
            if (r_flush_left <= 4'd1) begin
                w_state_nxt      = S_RUN;
                w_flush_left_nxt = 4'd0;
            end
        end else if (load_use_req) begin
            // Branch requests are dropped here; the hazard unit re-presents them.
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end else if (branch_req) begin
            ifid_flush = 1'b1;
            if (BRANCH_SLOTS > 1) begin
                w_state_nxt      = S_FLUSH;
                w_flush_left_nxt = c_slots_m1;
            end
        end
    end

    // This cycle is the MAX_WAIT-th consecutive wait cycle (or later).
    assign w_wait_hit = ({1'b0, r_wait_cnt} + 9'd1) >= {1'b0, c_max_wait};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_RUN;
            r_flush_left  <= 4'd0;
            r_wait_cnt    <= 8'd0;
            r_mem_timeout <= 1'b0;
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_flush_left <= w_flush_left_nxt;
            if (mem_wait) begin
                if (r_wait_cnt != c_max_wait) begin
                    r_wait_cnt <= r_wait_cnt + 8'd1;
                end
                if (w_wait_hit) begin
                    r_mem_timeout <= 1'b1;
                end
            end else begin
                r_wait_cnt <= 8'd0;
            end
            if (!pc_we && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + c_cnt_one;
            end
            if (ifid_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + c_cnt_one;
            end
        end
    end

    assign mem_timeout = r_mem_timeout;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stall_ctrl
// Description : Self-checking bench for pipe_stall_ctrl. Two instances:
//               A (BRANCH_SLOTS=2, MAX_WAIT=4, CNT_W=2) and
//               B (BRANCH_SLOTS=3, MAX_WAIT=15, CNT_W=16). Vector rows hold
//               inputs and expected outputs; expectations are queued when a
//               row is driven and compared on the following falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stall_ctrl;

    // ctl = {pc_we, ifid_we, ifid_flush, idex_bubble, pipe_hold, mem_timeout}
    localparam logic [5:0] c_rst  = 6'b001100;
    localparam logic [5:0] c_idle = 6'b110000;
    localparam logic [5:0] c_stl  = 6'b000100;
    localparam logic [5:0] c_fl   = 6'b111000;
    localparam logic [5:0] c_mw   = 6'b000010;
    localparam logic [5:0] c_to   = 6'b000001;

    typedef struct {
        logic       sel;     // 0 = instance A, 1 = instance B
        logic       rst;
        logic       lu;
        logic       br;
        logic       mw;
        logic [5:0] ctl;
        int         s;
        int         f;
        int         row;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_lu, a_br, a_mw;
    logic        a_pc_we, a_ifid_we, a_ifid_flush, a_idex_bubble, a_pipe_hold, a_mem_timeout;
    logic [1:0]  a_stall_cnt, a_flush_cnt;
    logic        b_rst, b_lu, b_br, b_mw;
    logic        b_pc_we, b_ifid_we, b_ifid_flush, b_idex_bubble, b_pipe_hold, b_mem_timeout;
    logic [15:0] b_stall_cnt, b_flush_cnt;

    pipe_stall_ctrl #(.BRANCH_SLOTS(2), .MAX_WAIT(4), .CNT_W(2)) dut_a (
        .clk(clk), .rst(a_rst), .load_use_req(a_lu), .branch_req(a_br), .mem_wait(a_mw),
        .pc_we(a_pc_we), .ifid_we(a_ifid_we), .ifid_flush(a_ifid_flush),
        .idex_bubble(a_idex_bubble), .pipe_hold(a_pipe_hold), .mem_timeout(a_mem_timeout),
        .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    pipe_stall_ctrl #(.BRANCH_SLOTS(3), .MAX_WAIT(15), .CNT_W(16)) dut_b (
        .clk(clk), .rst(b_rst), .load_use_req(b_lu), .branch_req(b_br), .mem_wait(b_mw),
        .pc_we(b_pc_we), .ifid_we(b_ifid_we), .ifid_flush(b_ifid_flush),
        .idex_bubble(b_idex_bubble), .pipe_hold(b_pipe_hold), .mem_timeout(b_mem_timeout),
        .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    vec_t tbl[$];
    vec_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic sel, input logic rst, input logic lu, input logic br,
                       input logic mw, input logic [5:0] ctl, input int s, input int f);
        vec_t v;
        v.sel = sel; v.rst = rst; v.lu = lu; v.br = br; v.mw = mw;
        v.ctl = ctl; v.s = s; v.f = f; v.row = tbl.size();
        tbl.push_back(v);
    endtask

    // Scoreboard checker: compare the oldest queued expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            vec_t e;
            logic [5:0] act_ctl;
            int act_s, act_f;
            e = sb.pop_front();
            if (e.sel) begin
                act_ctl = {b_pc_we, b_ifid_we, b_ifid_flush, b_idex_bubble, b_pipe_hold, b_mem_timeout};
                act_s   = int'(b_stall_cnt);
                act_f   = int'(b_flush_cnt);
            end else begin
                act_ctl = {a_pc_we, a_ifid_we, a_ifid_flush, a_idex_bubble, a_pipe_hold, a_mem_timeout};
                act_s   = int'(a_stall_cnt);
                act_f   = int'(a_flush_cnt);
            end
            total += 3;
            if (act_ctl !== e.ctl) begin
                bad++;
                $display("FAIL ctl dut=%0d row=%0d got=%b want=%b", e.sel, e.row, act_ctl, e.ctl);
            end
            if (act_s != e.s) begin
                bad++;
                $display("FAIL stall_cnt dut=%0d row=%0d got=%0d want=%0d", e.sel, e.row, act_s, e.s);
            end
            if (act_f != e.f) begin
                bad++;
                $display("FAIL flush_cnt dut=%0d row=%0d got=%0d want=%0d", e.sel, e.row, act_f, e.f);
            end
        end
    end

    initial begin
        a_rst = 1'b1; a_lu = 1'b0; a_br = 1'b0; a_mw = 1'b0;
        b_rst = 1'b1; b_lu = 1'b0; b_br = 1'b0; b_mw = 1'b0;
        repeat (2) @(posedge clk);

        // ---- Instance B: BRANCH_SLOTS=3 ----
        //   sel rst lu br mw  ctl      stall flush
        add(1, 1, 0, 0, 0, c_rst,  0, 0);
        add(1, 0, 0, 1, 0, c_fl,   0, 0);  // branch, enters 3-slot flush
        add(1, 0, 0, 0, 0, c_fl,   0, 1);
        add(1, 1, 0, 0, 0, c_rst,  0, 2);  // reset aborts flush
        add(1, 1, 0, 0, 0, c_rst,  0, 0);
        add(1, 0, 0, 0, 0, c_idle, 0, 0);  // back in RUN
        add(1, 0, 0, 1, 0, c_fl,   0, 0);
        add(1, 0, 0, 0, 0, c_fl,   0, 1);  // flush_left now 1
        add(1, 0, 0, 0, 1, c_mw,   0, 2);  // 3-cycle wait mid-flush
        add(1, 0, 0, 0, 1, c_mw,   1, 2);
        add(1, 0, 0, 0, 1, c_mw,   2, 2);
        add(1, 0, 1, 0, 0, c_fl,   3, 2);  // last flush slot, load-use squashed
        add(1, 0, 0, 0, 0, c_idle, 3, 3);
        add(1, 0, 1, 0, 0, c_stl,  3, 3);  // load-use stall
        add(1, 0, 0, 0, 0, c_idle, 4, 3);
        add(1, 0, 1, 1, 0, c_stl,  4, 3);  // load-use wins over branch
        add(1, 0, 0, 1, 0, c_fl,   5, 3);  // branch re-presented
        add(1, 0, 0, 1, 0, c_fl,   5, 4);  // ignored in FLUSH
        add(1, 0, 0, 0, 0, c_fl,   5, 5);
        add(1, 0, 0, 0, 0, c_idle, 5, 6);
        add(1, 0, 1, 1, 1, c_mw,   5, 6);  // mem_wait beats both requests
        add(1, 0, 0, 0, 0, c_idle, 6, 6);
        add(1, 1, 0, 1, 1, c_rst,  6, 6);  // reset beats mem_wait
        add(1, 0, 0, 0, 0, c_idle, 0, 0);

        // ---- Instance A: BRANCH_SLOTS=2, MAX_WAIT=4, CNT_W=2 ----
        add(0, 1, 0, 0, 0, c_rst,  0, 0);
        add(0, 0, 1, 0, 0, c_stl,  0, 0);
        add(0, 0, 0, 0, 0, c_idle, 1, 0);
        add(0, 0, 0, 1, 0, c_fl,   1, 0);  // 2-slot branch
        add(0, 0, 1, 0, 0, c_fl,   1, 1);  // load-use ignored in slot 2
        add(0, 0, 0, 0, 0, c_idle, 1, 2);
        add(0, 0, 0, 0, 1, c_mw,   1, 2);  // 3-cycle wait: no timeout
        add(0, 0, 0, 0, 1, c_mw,   2, 2);
        add(0, 0, 0, 0, 1, c_mw,   3, 2);
        add(0, 0, 0, 0, 0, c_idle, 3, 2);  // stall_cnt saturated at 3
        add(0, 0, 0, 0, 1, c_mw,   3, 2);  // 4-cycle wait: timeout
        add(0, 0, 0, 0, 1, c_mw,   3, 2);
        add(0, 0, 0, 0, 1, c_mw,   3, 2);
        add(0, 0, 0, 0, 1, c_mw,   3, 2);
        add(0, 0, 0, 0, 1, c_mw | c_to,   3, 2);
        add(0, 0, 0, 0, 0, c_idle | c_to, 3, 2);  // sticky after wait drops
        add(0, 0, 0, 1, 0, c_fl | c_to,   3, 2);
        add(0, 0, 0, 0, 0, c_fl | c_to,   3, 3);
        add(0, 0, 0, 1, 0, c_fl | c_to,   3, 3);  // flush_cnt saturated
        add(0, 0, 0, 0, 0, c_fl | c_to,   3, 3);
        add(0, 1, 0, 0, 0, c_rst | c_to,  3, 3);  // cleared at this edge
        add(0, 0, 0, 0, 0, c_idle, 0, 0);

        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            if (tbl[i].sel) begin
                a_rst = 1'b1; a_lu = 1'b0; a_br = 1'b0; a_mw = 1'b0;
                b_rst = tbl[i].rst; b_lu = tbl[i].lu; b_br = tbl[i].br; b_mw = tbl[i].mw;
            end else begin
                b_rst = 1'b1; b_lu = 1'b0; b_br = 1'b0; b_mw = 1'b0;
                a_rst = tbl[i].rst; a_lu = tbl[i].lu; a_br = tbl[i].br; a_mw = tbl[i].mw;
            end
            sb.push_back(tbl[i]);
        end

        for (int k = 0; k < 10 && sb.size() != 0; k++) begin
            @(negedge clk);
        end
        #1;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain got=%0d pending want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Pipeline-control responder that consumes the hazard unit's stall/branch requests and the data-memory wait.
- Drives PC write enable, IF/ID write/flush, ID/EX bubble insertion and a downstream hold for the 5-stage MIPS pipeline.
- Sequences multi-cycle branch flushes and times out stuck memory waits.
- Keeps saturating stall/flush performance counters.

Parameters:
- BRANCH_SLOTS, 1: consecutive IF/ID flush cycles per taken branch/jump (1..15).
- MAX_WAIT, 15: consecutive mem_wait cycles that trigger mem_timeout (1..255).
- CNT_W, 16: width of the performance counters.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- load_use_req  input  1  load-use hazard from the hazard unit (ID instruction depends on the load in EX).
- branch_req  input  1  control transfer resolved in ID (NPCOp != 0).
- mem_wait  input  1  data memory not ready; whole pipeline must freeze.
- pc_we  output  1  PC register write enable.
- ifid_we  output  1  IF/ID register write enable.
- ifid_flush  output  1  IF/ID loads NOP.
- idex_bubble  output  1  ID/EX loads NOP (control zeroed).
- pipe_hold  output  1  EX/MEM and MEM/WB hold their contents.
- mem_timeout  output  1  sticky: mem_wait held MAX_WAIT consecutive cycles.
- stall_cnt  output  CNT_W  cycles with pc_we=0, saturating.
- flush_cnt  output  CNT_W  cycles with ifid_flush=1, saturating.

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high; it is sampled only on the rising edge.
- Registered state: state {RUN, FLUSH}, flush_left (4 b), wait_cnt (8 b), mem_timeout, stall_cnt, flush_cnt.
- Control outputs are combinational from the current state and the current-cycle inputs, with zero-cycle latency.
- While rst=1, overriding all other rules:
  - pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1, pipe_hold=0.
  - At the clock edge: state←RUN, flush_left←0, wait_cnt←0, mem_timeout←0, both counters←0.
  - A reset asserted mid-FLUSH or mid-wait aborts the sequence immediately.
- Priority, highest first: rst > mem_wait > load_use_req > branch_req.
- mem_wait=1 (any state):
  - pc_we=0, ifid_we=0, ifid_flush=0, idex_bubble=0, pipe_hold=1.
  - state and flush_left are frozen.
  - wait_cnt increments, saturating at MAX_WAIT. When wait_cnt+1 reaches MAX_WAIT, mem_timeout←1 and stays set until rst.
  - mem_wait=0 clears wait_cnt to 0.
- RUN, load_use_req=1:
  - pc_we=0, ifid_we=0, idex_bubble=1, ifid_flush=0. State stays RUN.
  - A simultaneous branch_req is ignored; the hazard unit re-presents it after the stall.
- RUN, branch_req=1, load_use_req=0:
  - pc_we=1, ifid_we=1, ifid_flush=1.
  - If BRANCH_SLOTS>1: state←FLUSH, flush_left←BRANCH_SLOTS-1.
- FLUSH, no mem_wait:
  - pc_we=1, ifid_we=1, ifid_flush=1, idex_bubble=0.
  - flush_left decrements each cycle; at flush_left=1 the next state is RUN.
  - load_use_req and branch_req are ignored (the ID contents are squashed).
- RUN with no requests: pc_we=1, ifid_we=1, all others 0.
- Counters:
  - stall_cnt increments every non-reset cycle with pc_we=0, which includes mem_wait cycles.
  - flush_cnt increments every cycle with ifid_flush=1 and rst=0.
  - Both saturate at 2^CNT_W-1 and never wrap.
- pipe_hold=1 only under mem_wait.

Test Plan:
- Reset: rst=1 for 2 cycles during a BRANCH_SLOTS=3 flush → ifid_flush=1, idex_bubble=1, pc_we=0. After release: state RUN, counters 0, pc_we=1.
- Load-use: load_use_req=1 for 1 cycle → that cycle pc_we=0, ifid_we=0, idex_bubble=1; next cycle pc_we=1. stall_cnt=1, flush_cnt=0.
- Branch, BRANCH_SLOTS=2: branch_req pulse at cycle 5 → ifid_flush=1 in cycles 5 and 6, pc_we=1 throughout, RUN at cycle 7, flush_cnt=2. A load_use_req in cycle 6 is ignored.
- Simultaneous load_use_req and branch_req in RUN → stall only, ifid_flush=0. branch_req alone next cycle → flush.
- mem_wait for 3 cycles mid-FLUSH (BRANCH_SLOTS=3, flush_left=1):
  - During the wait: pipe_hold=1, ifid_flush=0, flush_left stays 1.
  - After the wait: one more flush cycle, then RUN.
  - stall_cnt=3.
- Timeout, MAX_WAIT=4: mem_wait held 4 cycles → mem_timeout=1 after the 4th edge and stays 1 after mem_wait drops. mem_wait held 3 cycles → mem_timeout=0. Counters with CNT_W=2 stop at 3.
